// File: rtl/alu_ft_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_ft_sched
// Purpose  : Lets N_REQ requesters share one fault-tolerant ALU. The ALU
//            executes each op twice, compares the two results, and recomputes
//            the op if they differ. This block provides round-robin
//            arbitration, a single pending skid slot, and an operand hold
//            while the ALU is mid-evaluation. It tracks the ALU's free-running
//            stage sequence from alu_fault and returns one response per op.
// Ports    : clk, rst                 clock / synchronous active-high reset
//            req_valid/ready [N_REQ]  per-requester handshake
//            req_a/b [32*N_REQ]       operands, requester i at [32i+:32]
//            req_ctrl [3*N_REQ]       ALUControl, requester i at [3i+:3]
//            alu_a/b/ctrl             operands driven to the shared FT ALU
//            alu_result/flags/fault   FT ALU registered result, flags, fault
//            rsp_valid/id/result/flags/retried  one-cycle response strobe
//            fault_cnt [16]           saturating count of retried ops
// Revision : 1.0 - initial release
// ============================================================================
module alu_ft_sched #(
  parameter int          N_REQ     = 2,
  parameter int          IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter logic [15:0] FAULT_SAT = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [3*N_REQ-1:0]   req_ctrl,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_ctrl,
  input  logic [31:0]          alu_result,
  input  logic [3:0]           alu_flags,
  input  logic                 alu_fault,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_retried,
  output logic [15:0]          fault_cnt
);

  // Mirror of the ALU's stage sequence.
  typedef enum logic [1:0] {
    ST_CAP1 = 2'd0,
    ST_CMP  = 2'd1,
    ST_RES  = 2'd2
  } trk_t;

  trk_t            r_trk;
  trk_t            w_trk_nxt;

  // Pending (skid) slot.
  logic            r_pend_v;
  logic [31:0]     r_pend_a;
  logic [31:0]     r_pend_b;
  logic [2:0]      r_pend_ctrl;
  logic [IDW-1:0]  r_pend_id;

  // Active op, held on the ALU operands while it evaluates.
  logic            r_busy;
  logic [31:0]     r_act_a;
  logic [31:0]     r_act_b;
  logic [2:0]      r_act_ctrl;
  logic [IDW-1:0]  r_act_id;

  logic [IDW-1:0]  r_ptr;

  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [31:0]     r_rsp_result;
  logic [3:0]      r_rsp_flags;
  logic            r_rsp_retried;
  logic [15:0]     r_fault_cnt;

  logic            w_slot_start;
  logic            w_load;
  logic            w_pend_free;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_idx;
  logic [N_REQ-1:0] w_grant;
  logic            w_accept;
  logic [31:0]     w_sel_a;
  logic [31:0]     w_sel_b;
  logic [2:0]      w_sel_ctrl;
  logic            w_done_ok;
  logic            w_done_retry;

  // (base + off) mod N_REQ, for base < N_REQ and off <= N_REQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IDW-1:0];
  endfunction

  // ---------------------------------------------------------------- tracker
  always_ff @(posedge clk) begin
    if (rst) r_trk <= ST_CAP1;
    else     r_trk <= w_trk_nxt;
  end

  always_comb begin
    w_trk_nxt = r_trk;
    case (r_trk)
      ST_CAP1: w_trk_nxt = ST_CMP;
      ST_CMP:  w_trk_nxt = ST_RES;
      // A clean compare overlaps RES with the next stage-1, so the next stage
      // is CMP. A mismatch makes the ALU spend this cycle recomputing.
      ST_RES:  w_trk_nxt = alu_fault ? ST_CAP1 : ST_CMP;
      default: w_trk_nxt = ST_CAP1;
    endcase
  end

  // The ALU samples its operands on every slot start. The RES case depends
  // on alu_fault combinationally.
  assign w_slot_start = (r_trk == ST_CAP1) | ((r_trk == ST_RES) & ~alu_fault);
  assign w_load       = w_slot_start & r_pend_v;
  assign w_pend_free  = ~r_pend_v | w_load;

  assign alu_a    = w_load ? r_pend_a    : r_act_a;
  assign alu_b    = w_load ? r_pend_b    : r_act_b;
  assign alu_ctrl = w_load ? r_pend_ctrl : r_act_ctrl;

  // ---------------------------------------------------------------- arbiter
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_gnt_any && req_valid[wrap_idx(r_ptr, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = wrap_idx(r_ptr, k);
      end
    end
    w_grant[w_gnt_idx] = w_gnt_any;
  end

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_sel_ctrl = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_gnt_idx == IDW'(k)) begin
        w_sel_a    = req_a[32*k +: 32];
        w_sel_b    = req_b[32*k +: 32];
        w_sel_ctrl = req_ctrl[3*k +: 3];
      end
    end
  end

  // No acceptance while in reset, so that every output reads zero.
  assign w_accept  = w_gnt_any & w_pend_free & ~rst;
  assign req_ready = (w_pend_free & ~rst) ? w_grant : '0;

  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (w_accept) r_ptr <= wrap_idx(w_gnt_idx, 1);
  end

  // ------------------------------------------------------ pending / active
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_v    <= 1'b0;
      r_pend_a    <= '0;
      r_pend_b    <= '0;
      r_pend_ctrl <= '0;
      r_pend_id   <= '0;
      r_busy      <= 1'b0;
      r_act_a     <= '0;
      r_act_b     <= '0;
      r_act_ctrl  <= '0;
      r_act_id    <= '0;
    end else begin
      if (w_accept) begin
        r_pend_v    <= 1'b1;
        r_pend_a    <= w_sel_a;
        r_pend_b    <= w_sel_b;
        r_pend_ctrl <= w_sel_ctrl;
        r_pend_id   <= w_gnt_idx;
      end else if (w_load) begin
        r_pend_v    <= 1'b0;
      end

      // With no pending op, the ALU re-evaluates the held operands. That
      // result belongs to no one.
      if (w_slot_start) begin
        r_busy <= r_pend_v;
        if (r_pend_v) begin
          r_act_a    <= r_pend_a;
          r_act_b    <= r_pend_b;
          r_act_ctrl <= r_pend_ctrl;
          r_act_id   <= r_pend_id;
        end
      end
    end
  end

  // ------------------------------------------------------------ completion
  // Outside reset, CAP1 is reached only from a faulted RES, and busy holds
  // across that RES. So busy in CAP1 means the recompute result is ready.
  assign w_done_ok    = r_busy & (r_trk == ST_RES) & ~alu_fault;
  assign w_done_retry = r_busy & (r_trk == ST_CAP1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_result  <= '0;
      r_rsp_flags   <= '0;
      r_rsp_retried <= 1'b0;
      r_fault_cnt   <= '0;
    end else begin
      r_rsp_valid <= w_done_ok | w_done_retry;
      if (w_done_ok | w_done_retry) begin
        r_rsp_id      <= r_act_id;
        r_rsp_result  <= alu_result;
        r_rsp_flags   <= alu_flags;
        r_rsp_retried <= w_done_retry;
      end
      if (w_done_retry && (r_fault_cnt != FAULT_SAT)) begin
        r_fault_cnt <= r_fault_cnt + 16'd1;
      end
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign rsp_retried = r_rsp_retried;
  assign fault_cnt   = r_fault_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_ft_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_ft_sched
// Purpose  : Directed bench for alu_ft_sched. A behavioural FT ALU drives the
//            alu_* inputs; it faults in RES whenever it holds SUB with A==B.
//            An in-order scoreboard of accepted ops predicts each response.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_ft_sched;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready, req_ready_s;
  logic [32*N-1:0] req_a, req_b;
  logic [3*N-1:0]  req_ctrl;
  logic [31:0]   alu_a, alu_b, alu_a_s, alu_b_s;
  logic [2:0]    alu_ctrl, alu_ctrl_s;
  logic [31:0]   alu_result;
  logic [3:0]    alu_flags;
  logic          alu_fault;
  logic          rsp_valid, rsp_valid_s;
  logic [0:0]    rsp_id, rsp_id_s;
  logic [31:0]   rsp_result, rsp_result_s;
  logic [3:0]    rsp_flags, rsp_flags_s;
  logic          rsp_retried, rsp_retried_s;
  logic [15:0]   fault_cnt, fault_cnt_s;

  always #5 clk = ~clk;

  alu_ft_sched #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_fault(alu_fault),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_retried(rsp_retried), .fault_cnt(fault_cnt));

  // Second instance with a low saturation point. Its inputs are identical, so
  // its behaviour is identical; only fault_cnt is checked.
  alu_ft_sched #(.N_REQ(N), .FAULT_SAT(16'd5)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a_s), .alu_b(alu_b_s), .alu_ctrl(alu_ctrl_s),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_fault(alu_fault),
    .rsp_valid(rsp_valid_s), .rsp_id(rsp_id_s), .rsp_result(rsp_result_s),
    .rsp_flags(rsp_flags_s), .rsp_retried(rsp_retried_s), .fault_cnt(fault_cnt_s));

  // ---------------------------------------------------------- ALU function
  // Returns {Zero, Carry, OverFlow, Negative, result}.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic cy, v;
    s = '0; cy = 1'b0; v = 1'b0;
    case (c)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; cy = s[32];
                  v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; cy = s[32];
                  v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      default: r = a ^ b;
    endcase
    return {(r == 32'd0), cy, v, r[31], r};
  endfunction

  // ------------------------------------------------------ behavioural FT ALU
  // Stage 0 = stage-1 capture, 1 = compare, 2 = result.
  int          m_stg;
  logic [31:0] m_la, m_lb;
  logic [2:0]  m_lc;

  always @(posedge clk) begin
    if (rst) begin
      m_stg <= 0; m_la <= '0; m_lb <= '0; m_lc <= '0;
    end else begin
      if (m_stg == 0 || (m_stg == 2 && !alu_fault)) begin
        m_la <= alu_a; m_lb <= alu_b; m_lc <= alu_ctrl;
      end
      case (m_stg)
        0: m_stg <= 1;
        1: m_stg <= 2;
        default: m_stg <= alu_fault ? 0 : 1;
      endcase
    end
  end

  assign alu_fault = (m_stg == 2) && (m_lc == 3'd1) && (m_la == m_lb);
  assign {alu_flags, alu_result} = alu_f(m_la, m_lb, m_lc);

  // --------------------------------------------------------------- checking
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
  } exp_t;

  exp_t        exp_q[$];
  logic [66:0] q0[$], q1[$];
  logic [N-1:0] acc_seen;
  int          m_ptr, m_cnt, m_cnt_sat, cyc, rsp_seen;
  int          rsp_log[$];
  logic [31:0] last_result;
  logic [3:0]  last_flags;
  logic        last_retried;
  logic [1:0]  snap_rdy[32];
  logic [31:0] snap_alua[32];
  logic        snap_rspv[32];

  initial begin
    m_ptr = 0; m_cnt = 0; m_cnt_sat = 0; cyc = -1; rsp_seen = 0; acc_seen = '0;
  end

  always @(negedge clk) begin
    int g;
    exp_t e;
    logic [35:0] ref_v;
    if (rst) begin
      exp_q.delete(); rsp_log.delete();
      m_ptr = 0; m_cnt = 0; m_cnt_sat = 0; cyc = -1; rsp_seen = 0; acc_seen = '0;
    end else begin
      cyc++;
      acc_seen = req_valid & req_ready;
      if (cyc >= 0 && cyc < 32) begin
        snap_rdy[cyc] = req_ready; snap_alua[cyc] = alu_a; snap_rspv[cyc] = rsp_valid;
      end
      if (req_ready != '0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        chk("arb_grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      end
      for (int i = 0; i < N; i++) begin
        if (acc_seen[i]) begin
          e.id = i[0]; e.a = req_a[32*i +: 32]; e.b = req_b[32*i +: 32]; e.c = req_ctrl[3*i +: 3];
          exp_q.push_back(e);
          m_ptr = (i + 1) % N;
        end
      end
      if (rsp_valid) begin
        rsp_seen++;
        rsp_log.push_back(int'(rsp_id));
        last_result = rsp_result; last_flags = rsp_flags; last_retried = rsp_retried;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          ref_v = alu_f(e.a, e.b, e.c);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_result", rsp_result, ref_v[31:0]);
          chk("rsp_flags", 32'(rsp_flags), 32'(ref_v[35:32]));
          chk("rsp_retried", 32'(rsp_retried), 32'((e.c == 3'd1) && (e.a == e.b)));
          if ((e.c == 3'd1) && (e.a == e.b)) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_sat < 5) m_cnt_sat++;
          end
        end
      end
      chk("fault_cnt", 32'(fault_cnt), m_cnt);
      chk("fault_cnt_sat", 32'(fault_cnt_s), m_cnt_sat);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic present();
    req_valid = {q1.size() != 0, q0.size() != 0};
    if (q0.size() != 0) {req_a[31:0], req_b[31:0], req_ctrl[2:0]} = q0[0];
    else                {req_a[31:0], req_b[31:0], req_ctrl[2:0]} = '0;
    if (q1.size() != 0) {req_a[63:32], req_b[63:32], req_ctrl[5:3]} = q1[0];
    else                {req_a[63:32], req_b[63:32], req_ctrl[5:3]} = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (acc_seen[0] && q0.size() != 0) void'(q0.pop_front());
    if (acc_seen[1] && q1.size() != 0) void'(q1.pop_front());
    acc_seen = '0;
    present();
  endtask

  task automatic wait_drain(input int max_cyc);
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || exp_q.size() != 0) && t < max_cyc) begin
      tick();
      t++;
    end
    if (t >= max_cyc) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int found;
    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_ctrl = '0;

    // Single op from reset: 5 + 3.
    q0.push_back({32'd5, 32'd3, 3'd0});
    repeat (3) tick();
    rst = 1'b0;
    wait_drain(200);
    chk("single_ready_c0", 32'(snap_rdy[0]), 32'd1);
    chk("single_alua_c2", snap_alua[2], 32'd5);
    chk("single_rspv_c4", 32'(snap_rspv[4]), 32'd0);
    chk("single_rspv_c5", 32'(snap_rspv[5]), 32'd1);
    chk("single_result", last_result, 32'd8);
    chk("single_retried", 32'(last_retried), 32'd0);

    // Reset in CMP with one op busy and one pending.
    q0.push_back({32'd1, 32'd2, 3'd0});
    q0.push_back({32'd3, 32'd4, 3'd0});
    q0.push_back({32'd5, 32'd6, 3'd0});
    found = 0;
    for (int t = 0; t < 80 && found == 0; t++) begin
      tick();
      if (m_stg == 1 && exp_q.size() == 2) found = 1;
    end
    chk("midop_setup", found, 32'd1);
    rst = 1'b1;
    q0.delete(); q1.delete();
    present();
    tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midop_alu_ops", {alu_a ^ alu_b, 29'd0, alu_ctrl}, 32'd0);
    chk("midop_rsp_regs", rsp_result | {27'd0, rsp_flags, rsp_retried}, 32'd0);
    chk("midop_misc", {14'd0, fault_cnt, req_ready}, 32'd0);
    chk("midop_alu_a", alu_a, 32'd0);
    repeat (12) tick();
    chk("midop_no_rsp", rsp_seen, 32'd0);

    // Contention: both requesters held valid.
    for (int i = 0; i < 4; i++) begin
      q0.push_back({32'd100 + 32'(i), 32'd3, 3'(i)});
      q1.push_back({32'hFFFF_FFF0 + 32'(i), 32'h20, 3'(i + 1)});
    end
    wait_drain(400);
    chk("contention_count", rsp_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < rsp_log.size(); i++)
      chk("contention_id", rsp_log[i], i % 2);

    // Fault path: 7 - 7 mismatches on first compare.
    q0.push_back({32'd7, 32'd7, 3'd1});
    wait_drain(200);
    chk("fault_result", last_result, 32'd0);
    chk("fault_flags", 32'(last_flags), 32'hC);
    chk("fault_retried", 32'(last_retried), 32'd1);
    chk("fault_cnt_one", 32'(fault_cnt), 32'd1);

    // Back-to-back from reset.
    rst = 1'b1;
    q0.push_back({32'd10, 32'd1, 3'd0});
    q0.push_back({32'd20, 32'd1, 3'd0});
    q0.push_back({32'd30, 32'd1, 3'd0});
    repeat (2) tick();
    rst = 1'b0;
    wait_drain(200);
    chk("b2b_alua_c2", snap_alua[2], 32'd10);
    chk("b2b_ready_c1", 32'(snap_rdy[1]), 32'd0);
    chk("b2b_ready_c3", 32'(snap_rdy[3]), 32'd0);
    chk("b2b_alua_c4", snap_alua[4], 32'd20);
    chk("b2b_ready_c4", 32'(snap_rdy[4]), 32'd1);
    chk("b2b_rspv_c5", 32'(snap_rspv[5]), 32'd1);
    chk("b2b_alua_c6", snap_alua[6], 32'd30);
    chk("b2b_rspv_c7", 32'(snap_rspv[7]), 32'd1);

    // Saturation: eight retried ops against a limit of five.
    for (int k = 1; k <= 4; k++) begin
      q0.push_back({32'(k), 32'(k), 3'd1});
      q1.push_back({32'(k + 8), 32'(k + 8), 3'd1});
    end
    wait_drain(600);
    chk("sat_cnt_main", 32'(fault_cnt), 32'd8);
    chk("sat_cnt_limit", 32'(fault_cnt_s), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
